// File: rtl/axi4_wr_burst_master_if.sv
// ============================================================================
// axi4_wr_burst_master_if : command, write-data stream and AXI4 write channels
// Rev 1.0
// ============================================================================
`default_nettype none

interface axi4_wr_burst_master_if #(
  parameter int ASIZE = 32,
  parameter int DSIZE = 64,
  parameter int LSIZE = 8,
  parameter int TSIZE = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [ASIZE-1:0] cmd_addr;
  logic [TSIZE-1:0] cmd_beats;

  logic             in_valid;
  logic             in_ready;
  logic [DSIZE-1:0] in_data;

  logic             axi_awvalid;
  logic             axi_awready;
  logic [ASIZE-1:0] axi_awaddr;
  logic [LSIZE-1:0] axi_awlen;

  logic             axi_wvalid;
  logic             axi_wready;
  logic [DSIZE-1:0] axi_wdata;
  logic             axi_wlast;

  logic             axi_bvalid;
  logic             axi_bready;
  logic [1:0]       axi_bresp;

  logic             done;
  logic             err;

  modport master (
    input  cmd_valid, cmd_addr, cmd_beats,
    output cmd_ready,
    input  in_valid, in_data,
    output in_ready,
    output axi_awvalid, axi_awaddr, axi_awlen,
    input  axi_awready,
    output axi_wvalid, axi_wdata, axi_wlast,
    input  axi_wready,
    input  axi_bvalid, axi_bresp,
    output axi_bready,
    output done, err
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_beats,
    input  cmd_ready,
    output in_valid, in_data,
    input  in_ready,
    input  axi_awvalid, axi_awaddr, axi_awlen,
    output axi_awready,
    input  axi_wvalid, axi_wdata, axi_wlast,
    output axi_wready,
    output axi_bvalid, axi_bresp,
    input  axi_bready,
    input  done, err
  );
endinterface

`default_nettype wire

// File: rtl/axi4_wr_burst_master.sv
// ============================================================================
// axi4_wr_burst_master : splits a beat-count transfer into AXI4 write bursts,
// one burst outstanding. AXI4_WR_BURST_4K_SPLIT_EN enables 4 KB splitting.
// Rev 1.0
// ============================================================================
`default_nettype none

module axi4_wr_burst_master #(
  parameter int ASIZE     = 32,
  parameter int DSIZE     = 64,
  parameter int LSIZE     = 8,
  parameter int BURST_LEN = 16,
  parameter int TSIZE     = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  axi4_wr_burst_master_if.master        bus_if
);

  localparam int BSHIFT = $clog2(DSIZE / 8);
  localparam int LW     = LSIZE + 1;
  localparam int T1     = (TSIZE > LW) ? TSIZE : LW;
  localparam int CW     = ((T1 > 13) ? T1 : 13) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AW   = 2'd1,
    S_W    = 2'd2,
    S_B    = 2'd3
  } state_e;

  state_e           state_q;
  logic [ASIZE-1:0] addr_q;
  logic [TSIZE-1:0] rem_q;
  logic [LW-1:0]    beat_q;
  logic             done_q;
  logic             err_q;

  logic [CW-1:0]    rem_ext;
  logic [CW-1:0]    lim;
  logic [CW-1:0]    len_ext;
  logic [LW-1:0]    burst_len;
  logic [LW-1:0]    last_beat;
  logic [ASIZE-1:0] addr_step;
  logic             run;
  logic             beat_fire;
  logic             is_last;

  // Burst length derives only from addr_q/rem_q, which hold still from AW to B.
  always_comb begin
    rem_ext = CW'(rem_q);
    lim     = CW'(BURST_LEN);
`ifdef AXI4_WR_BURST_4K_SPLIT_EN
    if (((CW'(4096) - CW'(addr_q[11:0])) >> BSHIFT) < lim) begin
      lim = (CW'(4096) - CW'(addr_q[11:0])) >> BSHIFT;
    end
`endif
    len_ext = (rem_ext < lim) ? rem_ext : lim;
  end

  assign burst_len = len_ext[LW-1:0];
  assign last_beat = burst_len - LW'(1);
  assign addr_step = ASIZE'(burst_len) << BSHIFT;
  assign run       = ~rst_i;
  assign beat_fire = bus_if.in_valid & bus_if.axi_wready;
  assign is_last   = (beat_q == last_beat);

  // Reset gates every handshake output so nothing is presented in the rst cycle.
  assign bus_if.cmd_ready   = run & (state_q == S_IDLE);
  assign bus_if.in_ready    = run & (state_q == S_W) & bus_if.axi_wready;
  assign bus_if.axi_awvalid = run & (state_q == S_AW);
  assign bus_if.axi_awaddr  = addr_q;
  assign bus_if.axi_awlen   = last_beat[LSIZE-1:0];
  assign bus_if.axi_wvalid  = run & (state_q == S_W) & bus_if.in_valid;
  assign bus_if.axi_wdata   = bus_if.in_data;
  assign bus_if.axi_wlast   = run & (state_q == S_W) & is_last;
  assign bus_if.axi_bready  = run & (state_q == S_B);
  assign bus_if.done        = run & done_q;
  assign bus_if.err         = run & err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      beat_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus_if.cmd_valid) begin
            addr_q <= bus_if.cmd_addr;
            rem_q  <= bus_if.cmd_beats;
            beat_q <= '0;
            err_q  <= 1'b0;
            if (bus_if.cmd_beats == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= S_AW;
            end
          end
        end
        S_AW: begin
          if (bus_if.axi_awready) begin
            beat_q  <= '0;
            state_q <= S_W;
          end
        end
        S_W: begin
          if (beat_fire) begin
            if (is_last) begin
              beat_q  <= '0;
              state_q <= S_B;
            end else begin
              beat_q <= beat_q + LW'(1);
            end
          end
        end
        S_B: begin
          if (bus_if.axi_bvalid) begin
            if (bus_if.axi_bresp != 2'b00) begin
              err_q <= 1'b1;
            end
            rem_q  <= rem_q - TSIZE'(burst_len);
            addr_q <= addr_q + addr_step;
            if (rem_q == TSIZE'(burst_len)) begin
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_AW;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi4_wr_burst_master.sv
// ============================================================================
// tb_axi4_wr_burst_master : directed bench with a responsive AXI slave model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_axi4_wr_burst_master;

  localparam int ASIZE = 32, DSIZE = 64, LSIZE = 8, BURST_LEN = 16, TSIZE = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi4_wr_burst_master_if #(.ASIZE(ASIZE), .DSIZE(DSIZE), .LSIZE(LSIZE), .TSIZE(TSIZE)) bus ();

  axi4_wr_burst_master #(.ASIZE(ASIZE), .DSIZE(DSIZE), .LSIZE(LSIZE),
                         .BURST_LEN(BURST_LEN), .TSIZE(TSIZE)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_if (bus)
  );

  int checks = 0;
  int errors = 0;

  // slave/source knobs
  int aw_delay = 0;
  bit w_rand   = 1'b0;
  bit in_gap   = 1'b0;
  int bad_b    = 1 << 30;

  // monitor records
  int          cyc = 0, aw_n = 0, w_n = 0, b_n = 0, done_n = 0;
  int          acc_cyc = 0, done_cyc = 0, stab_viol = 0, order_viol = 0, pend_n = 0;
  bit          aw_open = 1'b0, prev_pend = 1'b0, in_fire = 1'b0, b_fire = 1'b0;
  logic [31:0] prev_addr;
  logic [7:0]  prev_len;
  logic [31:0] aw_addr_r [0:63];
  logic [7:0]  aw_len_r  [0:63];
  logic [63:0] w_data_r  [0:1023];
  logic        w_last_r  [0:1023];
  int          src_idx = 0;
  int          aw_cnt  = 0;

  function automatic logic [63:0] pat(input int k);
    return {32'(k) ^ 32'hC0DE_0000, 32'(k * 3 + 1)};
  endfunction

  // Mid-cycle monitor: a handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      aw_open = 1'b0; prev_pend = 1'b0; in_fire = 1'b0; b_fire = 1'b0;
    end else begin
      if (bus.axi_awvalid) begin
        if (prev_pend && (bus.axi_awaddr !== prev_addr || bus.axi_awlen !== prev_len))
          stab_viol = stab_viol + 1;
      end else if (prev_pend) begin
        stab_viol = stab_viol + 1;
      end
      prev_pend = bus.axi_awvalid && !bus.axi_awready;
      if (prev_pend) pend_n = pend_n + 1;
      prev_addr = bus.axi_awaddr;
      prev_len  = bus.axi_awlen;
      if (bus.axi_awvalid && bus.axi_awready) begin
        aw_addr_r[aw_n] = bus.axi_awaddr;
        aw_len_r[aw_n]  = bus.axi_awlen;
        aw_n = aw_n + 1;
        aw_open = 1'b1;
      end
      if (bus.axi_wvalid && !aw_open) order_viol = order_viol + 1;
      if (bus.axi_wvalid && bus.axi_wready) begin
        w_data_r[w_n] = bus.axi_wdata;
        w_last_r[w_n] = bus.axi_wlast;
        w_n = w_n + 1;
        if (bus.axi_wlast) aw_open = 1'b0;
      end
      in_fire = bus.in_valid && bus.in_ready;
      b_fire  = bus.axi_bvalid && bus.axi_bready;
      if (b_fire) b_n = b_n + 1;
      if (bus.cmd_valid && bus.cmd_ready) acc_cyc = cyc;
      if (bus.done) begin
        done_n = done_n + 1;
        done_cyc = cyc;
      end
    end
  end

  // Slave and data source, driven just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      bus.axi_awready = 1'b0; aw_cnt = 0;
      bus.axi_bvalid = 1'b0; bus.axi_bresp = 2'b00;
    end else begin
      if (bus.axi_awvalid) begin
        bus.axi_awready = (aw_cnt >= aw_delay);
        aw_cnt = aw_cnt + 1;
      end else begin
        bus.axi_awready = 1'b0; aw_cnt = 0;
      end
      if (bus.axi_bvalid === 1'b1 && b_fire) begin
        bus.axi_bvalid = 1'b0;
      end else if (bus.axi_bready) begin
        bus.axi_bvalid = 1'b1;
        bus.axi_bresp  = (b_n == bad_b) ? 2'b10 : 2'b00;
      end else begin
        bus.axi_bvalid = 1'b0;
      end
    end
    bus.axi_wready = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (in_fire) src_idx = src_idx + 1;
    if (in_fire || bus.in_valid !== 1'b1) bus.in_valid = in_gap ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.in_data = pat(src_idx);
  end

  task automatic issue_cmd(input logic [31:0] a, input logic [15:0] n, output bit ok);
    ok = 1'b0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_addr = a; bus.cmd_beats = n;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk); #2;
      if (bus.cmd_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      @(negedge clk); #2;
      ok = (done_n > d0);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    checks++;
    if ({bus.cmd_ready, bus.in_ready, bus.axi_awvalid, bus.axi_wvalid, bus.axi_wlast,
         bus.axi_bready, bus.done, bus.err} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000000", {bus.cmd_ready, bus.in_ready,
               bus.axi_awvalid, bus.axi_wvalid, bus.axi_wlast, bus.axi_bready, bus.done, bus.err});
    end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk); #2;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready); end
  endtask

  task automatic test_multi_burst();
    int a0 = aw_n, w0 = w_n, d0 = done_n, dm = 0, lm = 0;
    bit ok_c, ok_d;
    logic [31:0] ea [3] = '{32'h1000, 32'h1080, 32'h1100};
    logic [7:0]  el [3] = '{8'd15, 8'd15, 8'd7};
    issue_cmd(32'h1000, 16'd40, ok_c);
    wait_done(d0, ok_d);
    checks++;
    if (!(ok_c && ok_d)) begin errors++; $display("FAIL multi_complete: got accept=%0b done=%0b expected 1 1", ok_c, ok_d); end
    checks++;
    if (done_cyc - acc_cyc != 47) begin errors++; $display("FAIL multi_latency: got %0d expected 47", done_cyc - acc_cyc); end
    repeat (4) @(negedge clk); #2;
    checks++;
    if (done_n - d0 != 1) begin errors++; $display("FAIL multi_done_pulses: got %0d expected 1", done_n - d0); end
    checks++;
    if (aw_n - a0 != 3) begin errors++; $display("FAIL multi_aw_count: got %0d expected 3", aw_n - a0); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({aw_addr_r[a0+i], aw_len_r[a0+i]} !== {ea[i], el[i]}) begin
        errors++;
        $display("FAIL multi_aw%0d: got addr %h len %0d expected addr %h len %0d", i, aw_addr_r[a0+i], aw_len_r[a0+i], ea[i], el[i]);
      end
    end
    checks++;
    if (w_n - w0 != 40) begin errors++; $display("FAIL multi_w_count: got %0d expected 40", w_n - w0); end
    for (int i = 0; i < 40; i++) begin
      if (w_data_r[w0+i] !== pat(w0+i)) dm++;
      if (w_last_r[w0+i] !== (i == 15 || i == 31 || i == 39)) lm++;
    end
    checks++;
    if (dm != 0) begin errors++; $display("FAIL multi_w_data: got %0d bad beats expected 0", dm); end
    checks++;
    if (lm != 0) begin errors++; $display("FAIL multi_wlast: got %0d misplaced expected 0", lm); end
  endtask

  task automatic test_zero_beats();
    int a0 = aw_n, w0 = w_n, d0 = done_n;
    bit ok_c, ok_d;
    issue_cmd(32'h2000, 16'd0, ok_c);
    wait_done(d0, ok_d);
    checks++;
    if (!(ok_c && ok_d)) begin errors++; $display("FAIL zero_complete: got accept=%0b done=%0b expected 1 1", ok_c, ok_d); end
    checks++;
    if (done_cyc - acc_cyc != 1) begin errors++; $display("FAIL zero_done_latency: got %0d expected 1", done_cyc - acc_cyc); end
    repeat (5) @(negedge clk); #2;
    checks++;
    if ((aw_n - a0) + (w_n - w0) != 0) begin errors++; $display("FAIL zero_no_traffic: got aw %0d w %0d expected 0 0", aw_n - a0, w_n - w0); end
    checks++;
    if (done_n - d0 != 1) begin errors++; $display("FAIL zero_done_pulses: got %0d expected 1", done_n - d0); end
  endtask

  task automatic test_4k_boundary();
    int a0 = aw_n, w0 = w_n, d0 = done_n, lm = 0;
    bit ok_c, ok_d;
    issue_cmd(32'h0FC0, 16'd16, ok_c);
    wait_done(d0, ok_d);
    checks++;
    if (!(ok_c && ok_d)) begin errors++; $display("FAIL 4k_complete: got accept=%0b done=%0b expected 1 1", ok_c, ok_d); end
    checks++;
    if (w_n - w0 != 16) begin errors++; $display("FAIL 4k_w_count: got %0d expected 16", w_n - w0); end
`ifdef AXI4_WR_BURST_4K_SPLIT_EN
    checks++;
    if (aw_n - a0 != 2) begin errors++; $display("FAIL 4k_aw_count: got %0d expected 2", aw_n - a0); end
    checks++;
    if ({aw_addr_r[a0], aw_len_r[a0], aw_addr_r[a0+1], aw_len_r[a0+1]} !== {32'h0FC0, 8'd7, 32'h1000, 8'd7}) begin
      errors++;
      $display("FAIL 4k_aw: got %h/%0d %h/%0d expected 00000fc0/7 00001000/7", aw_addr_r[a0], aw_len_r[a0], aw_addr_r[a0+1], aw_len_r[a0+1]);
    end
    for (int i = 0; i < 16; i++) if (w_last_r[w0+i] !== (i == 7 || i == 15)) lm++;
`else
    checks++;
    if (aw_n - a0 != 1) begin errors++; $display("FAIL 4k_aw_count: got %0d expected 1", aw_n - a0); end
    checks++;
    if ({aw_addr_r[a0], aw_len_r[a0]} !== {32'h0FC0, 8'd15}) begin
      errors++;
      $display("FAIL 4k_aw: got %h/%0d expected 00000fc0/15", aw_addr_r[a0], aw_len_r[a0]);
    end
    for (int i = 0; i < 16; i++) if (w_last_r[w0+i] !== (i == 15)) lm++;
`endif
    checks++;
    if (lm != 0) begin errors++; $display("FAIL 4k_wlast: got %0d misplaced expected 0", lm); end
  endtask

  task automatic test_backpressure();
    int a0 = aw_n, w0 = w_n, d0 = done_n, s0 = stab_viol, o0 = order_viol, p0 = pend_n, dm = 0, lm = 0;
    bit ok_c, ok_d;
    aw_delay = 5; w_rand = 1'b1; in_gap = 1'b1;
    issue_cmd(32'h2000, 16'd20, ok_c);
    wait_done(d0, ok_d);
    aw_delay = 0; w_rand = 1'b0; in_gap = 1'b0;
    checks++;
    if (!(ok_c && ok_d)) begin errors++; $display("FAIL bp_complete: got accept=%0b done=%0b expected 1 1", ok_c, ok_d); end
    checks++;
    if (w_n - w0 != 20) begin errors++; $display("FAIL bp_w_count: got %0d expected 20", w_n - w0); end
    for (int i = 0; i < 20; i++) begin
      if (w_data_r[w0+i] !== pat(w0+i)) dm++;
      if (w_last_r[w0+i] !== (i == 15 || i == 19)) lm++;
    end
    checks++;
    if (dm + lm != 0) begin errors++; $display("FAIL bp_w_order: got %0d bad data %0d bad wlast expected 0 0", dm, lm); end
    checks++;
    if ({aw_addr_r[a0], aw_len_r[a0], aw_addr_r[a0+1], aw_len_r[a0+1]} !== {32'h2000, 8'd15, 32'h2080, 8'd3} || aw_n - a0 != 2) begin
      errors++;
      $display("FAIL bp_aw: got n=%0d %h/%0d %h/%0d expected n=2 00002000/15 00002080/3", aw_n - a0, aw_addr_r[a0], aw_len_r[a0], aw_addr_r[a0+1], aw_len_r[a0+1]);
    end
    checks++;
    if (pend_n - p0 != 10) begin errors++; $display("FAIL bp_aw_wait_cycles: got %0d expected 10", pend_n - p0); end
    checks++;
    if (stab_viol - s0 != 0) begin errors++; $display("FAIL bp_aw_stable: got %0d violations expected 0", stab_viol - s0); end
    checks++;
    if (order_viol - o0 != 0) begin errors++; $display("FAIL bp_w_before_aw: got %0d violations expected 0", order_viol - o0); end
  endtask

  task automatic test_bresp_error();
    int a0 = aw_n, b0 = b_n, d0 = done_n;
    bit ok_c, ok_d;
    bad_b = b_n + 1;
    issue_cmd(32'h3000, 16'd40, ok_c);
    wait_done(d0, ok_d);
    checks++;
    if (!(ok_c && ok_d)) begin errors++; $display("FAIL bresp_complete: got accept=%0b done=%0b expected 1 1", ok_c, ok_d); end
    checks++;
    if (bus.err !== 1'b1) begin errors++; $display("FAIL bresp_err_at_done: got %b expected 1", bus.err); end
    checks++;
    if (aw_n - a0 != 3 || b_n - b0 != 3) begin errors++; $display("FAIL bresp_all_bursts: got aw %0d b %0d expected 3 3", aw_n - a0, b_n - b0); end
    bad_b = 1 << 30;
    repeat (3) @(negedge clk); #2;
    checks++;
    if (bus.err !== 1'b1) begin errors++; $display("FAIL bresp_err_sticky: got %b expected 1", bus.err); end
    d0 = done_n;
    issue_cmd(32'h3000, 16'd0, ok_c);
    @(negedge clk); #2;
    checks++;
    if (bus.err !== 1'b0) begin errors++; $display("FAIL bresp_err_clear: got %b expected 0", bus.err); end
    wait_done(d0, ok_d);
  endtask

  task automatic test_rst_mid_burst();
    int a0 = aw_n, w0 = w_n, d0, dm = 0;
    bit ok_c, ok_d;
    issue_cmd(32'h4000, 16'd16, ok_c);
    for (int c = 0; c < 200 && w_n < w0 + 4; c++) begin @(negedge clk); #2; end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk); #2;
    checks++;
    if ({bus.axi_awvalid, bus.axi_wvalid, bus.axi_wlast, bus.axi_bready, bus.in_ready} !== 5'b0) begin
      errors++;
      $display("FAIL rst_mid_valids: got %b expected 00000", {bus.axi_awvalid, bus.axi_wvalid, bus.axi_wlast, bus.axi_bready, bus.in_ready});
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_cmd_ready: got %b expected 1", bus.cmd_ready); end
    repeat (5) @(negedge clk); #2;
    checks++;
    if (w_n - w0 != 4 || aw_n - a0 != 1) begin errors++; $display("FAIL rst_mid_abandon: got w %0d aw %0d expected 4 1", w_n - w0, aw_n - a0); end
    a0 = aw_n; w0 = w_n; d0 = done_n;
    issue_cmd(32'h5000, 16'd16, ok_c);
    wait_done(d0, ok_d);
    for (int i = 0; i < 16; i++) if (w_data_r[w0+i] !== pat(w0+i) || w_last_r[w0+i] !== (i == 15)) dm++;
    checks++;
    if (!(ok_c && ok_d) || aw_n - a0 != 1 || {aw_addr_r[a0], aw_len_r[a0]} !== {32'h5000, 8'd15}) begin
      errors++;
      $display("FAIL rst_mid_recover_aw: got ok=%0b%0b n=%0d %h/%0d expected ok=11 n=1 00005000/15", ok_c, ok_d, aw_n - a0, aw_addr_r[a0], aw_len_r[a0]);
    end
    checks++;
    if (w_n - w0 != 16 || dm != 0) begin errors++; $display("FAIL rst_mid_recover_w: got %0d beats %0d bad expected 16 0", w_n - w0, dm); end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_beats = '0;
    test_reset();
    test_multi_burst();
    test_zero_beats();
    test_4k_boundary();
    test_backpressure();
    test_bresp_error();
    test_rst_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/axi4_wr_burst_master.md
AXI4_WR_BURST_MASTER -- requirements
Module: axi4_wr_burst_master

Interface
REQ-001 Parameter ASIZE, default 32: AXI address width.
REQ-002 Parameter DSIZE, default 64: data width in bits; beat size is DSIZE/8 bytes, and DSIZE/8 is a power of two.
REQ-003 Parameter LSIZE, default 8: awlen width.
REQ-004 Parameter BURST_LEN, default 16: maximum beats per burst, range 1..2^LSIZE.
REQ-005 Parameter TSIZE, default 16: width of the transfer beat count.
REQ-006 clock  in  1  single clock for all logic.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 cmd_valid/cmd_ready  in/out  1/1  transfer command handshake.
REQ-009 cmd_addr  in  ASIZE  start byte address, beat-aligned.
REQ-010 cmd_beats  in  TSIZE  total beats in the transfer.
REQ-011 in_valid/in_ready  in/out  1/1  write data stream handshake.
REQ-012 in_data  in  DSIZE  write data beat.
REQ-013 axi_awvalid, axi_awready, axi_awaddr[ASIZE], axi_awlen[LSIZE]: AXI4 write address channel; this block is the master.
REQ-014 axi_wvalid, axi_wready, axi_wdata[DSIZE], axi_wlast: AXI4 write data channel; this block is the master.
REQ-015 axi_bvalid, axi_bready, axi_bresp[2]: AXI4 write response channel; this block is the master.
REQ-016 done  out  1  one-cycle pulse when the whole transfer has completed.
REQ-017 err  out  1  sticky flag; set on any bresp!=0; cleared when the next command is accepted.

Function
REQ-018 The block shall be a state machine with states IDLE, AW, W, B.
- IDLE: cmd_ready=1. On cmd_valid, latch addr and remaining=cmd_beats and clear err.
- If cmd_beats==0, stay IDLE, assert done the next cycle, and issue no AXI traffic.
- Otherwise go to AW.
REQ-019 In AW, compute len=min(remaining, BURST_LEN), further limited by REQ-035 when compiled in.
- Drive axi_awvalid=1, axi_awaddr=addr, axi_awlen=len-1.
- Hold all AW fields stable until axi_awready; then go to W.
REQ-020 In W:
- axi_wvalid=in_valid, axi_wdata=in_data, in_ready=axi_wready.
- No combinational path from axi_wready to in_valid.
- A beat transfers when in_valid&&axi_wready. The beat counter increments per beat.
- axi_wlast=1 exactly on beat len-1.
- After the last beat, go to B.
REQ-021 W beats shall never be presented before the AW handshake of the same burst completes; exactly one burst is outstanding at a time.
REQ-022 In B:
- axi_bready=1.
- On axi_bvalid: set err if bresp!=0, remaining-=len, addr+=len*(DSIZE/8).
- If the new remaining==0, go to IDLE and pulse done; else go to AW.
REQ-023 Address arithmetic shall be ASIZE-bit, modulo 2^ASIZE.
REQ-024 The beat counter is LSIZE+1 bits; remaining is TSIZE bits and never underflows.
REQ-025 cmd_ready=0 and in_ready=0 outside the states given in REQ-018 and REQ-020.
REQ-026 axi_bready=0 outside B.
REQ-027 A bresp error shall not abort the transfer; all bursts are still issued.
REQ-028 Output timing:
- AW, W and B control outputs are registered or a pure function of state plus the corresponding handshake input.
- A burst of N beats with no backpressure takes 1 (AW) + N (W) + 1 (B) cycles minimum.

Reset
REQ-029 While rst=1, the state shall be IDLE.
REQ-030 While rst=1: axi_awvalid=0, axi_wvalid=0, axi_wlast=0, axi_bready=0, in_ready=0, cmd_ready=0, done=0, err=0, counters=0.
REQ-031 rst asserted mid-burst shall abandon the burst immediately; no further AW/W beats are issued after the rst cycle.
REQ-032 cmd_ready shall assert on the first cycle after rst deasserts.

Configuration
REQ-033 The macro AXI4_WR_BURST_4K_SPLIT_EN selects 4 KB boundary splitting.
REQ-034 Without the macro, burst length shall follow REQ-019 only.
REQ-035 With the macro defined, len shall additionally be limited to (4096 - addr[11:0])/(DSIZE/8), so no burst crosses a 4 KB boundary.

Verification
REQ-036 Defaults; cmd_addr=0x1000, cmd_beats=40, no backpressure -> AW bursts at 0x1000/0x1080/0x1100 with awlen 15/15/7; wlast on beats 16/32/40; one done pulse.
REQ-037 cmd_beats=0 -> no AW/W activity; done pulses one cycle after acceptance.
REQ-038 cmd_addr=0x0FC0, cmd_beats=16 -> with macro: awlen 7 at 0x0FC0, then awlen 7 at 0x1000; without macro: single awlen 15 at 0x0FC0.
REQ-039 cmd_beats=20; axi_wready random 50%; in_valid gapped; awready delayed 5 cycles -> exactly 20 beats in order; awaddr/awlen stable while awvalid=1 and awready=0.
REQ-040 Second of three bursts returns bresp=2'b10 -> err=1 and stays set; third burst still issued; done pulses; next command acceptance clears err.
REQ-041 rst=1 for one cycle during beat 5 of a 16-beat burst -> all valids 0 next cycle; cmd_ready=1 the cycle after rst deasserts; a new command then completes normally.
